// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain with bubble collapsing, flush, occupancy and stall counters.
// Optional input skid register enabled by defining PIPE_SKID_BUFFER_EN.
module pipe_stage_chain #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         flush,
  output logic [$clog2(DEPTH+2)-1:0]   count,
  output logic [15:0]                  stall_cnt
);

  localparam int CW = $clog2(DEPTH+2);

  logic [DEPTH-1:0] v_r;
  logic [WIDTH-1:0] d_r [DEPTH];
  logic [DEPTH-1:0] v_nxt_s;
  logic [DEPTH-1:0] xfer_s;
  logic [DEPTH:0]   rdy_s;
  logic             src_valid_s;
  logic [WIDTH-1:0] src_data_s;
  logic             skid_nxt_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic [15:0]      stall_r;

  // Ready ripples from the output back to stage 0; an empty stage is always ready.
  always_comb begin : ready_chain
    logic r;
    r = out_ready;
    rdy_s[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy_s[k] = ~v_r[k] | r;
      r = rdy_s[k];
    end
  end

`ifdef PIPE_SKID_BUFFER_EN
  logic             skid_v_r;
  logic [WIDTH-1:0] skid_d_r;

  // Skid word has priority into stage 0; in_ready depends only on the skid register.
  always_comb begin
    in_ready = ~skid_v_r & ~flush;
    if (skid_v_r) begin
      src_valid_s = 1'b1;
      src_data_s  = skid_d_r;
    end else begin
      src_valid_s = in_valid & in_ready;
      src_data_s  = in_data;
    end
    if (flush) begin
      skid_nxt_s = 1'b0;
    end else if (skid_v_r) begin
      skid_nxt_s = ~rdy_s[0];
    end else begin
      skid_nxt_s = in_valid & in_ready & ~rdy_s[0];
    end
  end

  // Skid register: captures an accepted word that stage 0 cannot take yet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_v_r <= 1'b0;
      skid_d_r <= {WIDTH{1'b0}};
    end else begin
      skid_v_r <= skid_nxt_s;
      if (~skid_v_r & in_valid & in_ready & ~rdy_s[0]) begin
        skid_d_r <= in_data;
      end
    end
  end
`else
  // Without a skid register the input feeds stage 0 directly.
  always_comb begin
    in_ready    = rdy_s[0] & ~flush;
    src_valid_s = in_valid;
    src_data_s  = in_data;
    skid_nxt_s  = 1'b0;
  end
`endif

  // Transfers, next valid bits and next occupancy; flush overrides every transfer.
  always_comb begin
    xfer_s[0] = src_valid_s & rdy_s[0] & ~flush;
    for (int k = 1; k < DEPTH; k++) begin
      xfer_s[k] = v_r[k-1] & rdy_s[k] & ~flush;
    end
    count_nxt_s = {{(CW-1){1'b0}}, skid_nxt_s};
    for (int k = 0; k < DEPTH; k++) begin
      if (flush) begin
        v_nxt_s[k] = 1'b0;
      end else if (xfer_s[k]) begin
        v_nxt_s[k] = 1'b1;
      end else if (v_r[k] & rdy_s[k+1]) begin
        v_nxt_s[k] = 1'b0;
      end else begin
        v_nxt_s[k] = v_r[k];
      end
      count_nxt_s = count_nxt_s + {{(CW-1){1'b0}}, v_nxt_s[k]};
    end
  end

  // Stage registers; data only moves on a transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_r     <= {DEPTH{1'b0}};
      count_r <= {CW{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        d_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      v_r     <= v_nxt_s;
      count_r <= count_nxt_s;
      if (xfer_s[0]) begin
        d_r[0] <= src_data_s;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (xfer_s[k]) begin
          d_r[k] <= d_r[k-1];
        end
      end
    end
  end

  // Saturating stall counter; flush does not touch it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_r <= 16'h0000;
    end else if (v_r[DEPTH-1] & ~out_ready & (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end
  end

  assign out_valid = v_r[DEPTH-1];
  assign out_data  = d_r[DEPTH-1];
  assign count     = count_r;
  assign stall_cnt = stall_r;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain in its default build (WIDTH=16, DEPTH=2, no skid).
module tb_pipe_stage_chain;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        flush;
  logic [1:0]  count;
  logic [15:0] stall_cnt;

  int total;
  int bad;

  pipe_stage_chain #(.WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .count(count), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads two words into an empty chain while downstream stalls.
  task automatic push2(input logic [15:0] a, input logic [15:0] b);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = a;
    tick();
    in_data   = b;
    tick();
    in_valid  = 1'b0;
    in_data   = 16'h0000;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0; flush = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL rst_out_data got=%h exp=0000", out_data); end
    total++; if (count !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (stall_cnt !== 16'h0000) begin bad++; $display("FAIL rst_stall got=%h exp=0000", stall_cnt); end
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        in_data = 16'(i + 1);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
        in_data  = 16'h0000;
      end
      tick();
      if (i == 0 || i == 6) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_idle i=%0d got=%b exp=0", i, out_valid); end
      end else begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid i=%0d got=%b exp=1", i, out_valid); end
        total++; if (out_data !== 16'(i)) begin bad++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, out_data, 16'(i)); end
      end
    end
    total++; if (count !== 2'd0) begin bad++; $display("FAIL stream_count got=%0d exp=0", count); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hA001;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready1 got=%b exp=1", in_ready); end
    in_data = 16'hA002;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready2 got=%b exp=0", in_ready); end
    in_data = 16'hA003;
    tick();
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL stall_cnt1 got=%0d exp=1", stall_cnt); end
    total++; if (count !== 2'd2) begin bad++; $display("FAIL stall_count got=%0d exp=2", count); end
    total++; if (out_data !== 16'hA001) begin bad++; $display("FAIL stall_hold got=%h exp=a001", out_data); end
    tick();
    tick();
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stall_cnt3 got=%0d exp=3", stall_cnt); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== 16'hA002 || count !== 2'd1) begin bad++; $display("FAIL stall_drain data=%h count=%0d exp=a002/1", out_data, count); end
    tick();
    total++; if (count !== 2'd0 || stall_cnt !== 16'd3) begin bad++; $display("FAIL stall_empty count=%0d stall=%0d exp=0/3", count, stall_cnt); end
  endtask

  task automatic test_flush();
    push2(16'hAAAA, 16'hBBBB);
    total++; if (count !== 2'd2) begin bad++; $display("FAIL flush_full got=%0d exp=2", count); end
    flush = 1'b1; in_valid = 1'b1; in_data = 16'hCCCC;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    total++; if (count !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear count=%0d valid=%b exp=0/0", count, out_valid); end
    total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL flush_stall got=%0d exp=4", stall_cnt); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL flush_no_cccc valid=%b count=%0d exp=0/0", out_valid, count); end
  endtask

  task automatic test_back_to_back();
    push2(16'h1111, 16'h2222);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h3333;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (count !== 2'd2 || out_data !== 16'h2222) begin bad++; $display("FAIL b2b_swap count=%0d data=%h exp=2/2222", count, out_data); end
    tick();
    total++; if (out_data !== 16'h3333 || count !== 2'd1) begin bad++; $display("FAIL b2b_new data=%h count=%0d exp=3333/1", out_data, count); end
    tick();
    total++; if (count !== 2'd0 || stall_cnt !== 16'd4) begin bad++; $display("FAIL b2b_end count=%0d stall=%0d exp=0/4", count, stall_cnt); end
  endtask

  task automatic test_reset_mid();
    push2(16'h4444, 16'h5555);
    tick();
    total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL rmid_pre got=%0d exp=5", stall_cnt); end
    #3;
    reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL rmid_clear valid=%b count=%0d exp=0/0", out_valid, count); end
    total++; if (stall_cnt !== 16'h0000 || out_data !== 16'h0000) begin bad++; $display("FAIL rmid_regs stall=%h data=%h exp=0000/0000", stall_cnt, out_data); end
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h5A5A;
    tick();
    in_valid = 1'b0;
    total++; if (count !== 2'd1 || out_valid !== 1'b0) begin bad++; $display("FAIL rmid_accept count=%0d valid=%b exp=1/0", count, out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 16'h5A5A) begin bad++; $display("FAIL rmid_out valid=%b data=%h exp=1/5a5a", out_valid, out_data); end
    tick();
  endtask

  task automatic test_saturate();
    push2(16'h7777, 16'h8888);
    in_valid = 1'b1; in_data = 16'h9999;
    repeat (65600) tick();
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_stall got=%h exp=ffff", stall_cnt); end
    total++; if (count !== 2'd2 || in_ready !== 1'b0) begin bad++; $display("FAIL sat_full count=%0d ready=%b exp=2/0", count, in_ready); end
    total++; if (out_data !== 16'h7777) begin bad++; $display("FAIL sat_hold got=%h exp=7777", out_data); end
    in_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 16: payload bits per stage.
REQ-002 SHALL have parameter DEPTH, default 2: number of register stages, legal range 1..8.
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1: upstream has a word on in_data.
REQ-006 SHALL have port in_ready  output  1: chain accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  WIDTH: upstream payload.
REQ-008 SHALL have port out_valid  output  1: last stage holds a valid word.
REQ-009 SHALL have port out_ready  input  1: downstream consumes out_data this cycle.
REQ-010 SHALL have port out_data  output  WIDTH: last-stage payload.
REQ-011 SHALL have port flush  input  1: discard all in-flight words.
REQ-012 SHALL have port count  output  $clog2(DEPTH+2): number of valid words held.
REQ-013 SHALL have port stall_cnt  output  16: saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 Each stage k SHALL hold a valid bit v[k] and a WIDTH-bit data register d[k]; stage 0 is input side, stage DEPTH-1 drives out_valid/out_data.
REQ-015 Stage k ready SHALL be !v[k] | ready[k+1]; ready of the last stage is out_ready (bubble collapsing: an empty stage accepts even when downstream stalls).
REQ-016 A transfer into stage k SHALL occur when its upstream valid and ready[k] are both 1; d[k] loads only on a transfer, otherwise holds.
REQ-017 v[k] next SHALL be 1 on an incoming transfer, 0 if the word leaves without replacement, else unchanged.
REQ-018 With out_ready held 1 and no flush, a word accepted at edge N SHALL appear on out_data with out_valid=1 after edge N+DEPTH-1 (latency DEPTH cycles, one word per cycle throughput).
REQ-019 out_data SHALL equal d[DEPTH-1] regardless of out_valid.
REQ-020 flush=1 SHALL clear every valid bit at the next edge, force in_ready=0 in that cycle, and take priority over any simultaneous transfer (no word enters or counts as delivered).
REQ-021 count SHALL equal the number of set valid bits (plus skid, REQ-027) and update in the same edge as the valid bits.
REQ-022 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturate at 16'hFFFF, and be unaffected by flush.
REQ-023 When full with out_ready=0, in_ready SHALL be 0 and no stage state SHALL change.
REQ-024 Simultaneous accept at input and delivery at output SHALL leave count unchanged.

Reset
REQ-025 reset_n=0 SHALL immediately clear all valid bits, data registers to 0, count to 0, stall_cnt to 0; out_valid=0, out_data=0.
REQ-026 Reset asserted mid-transfer SHALL discard all words; after release the first edge with in_valid=1 and in_ready=1 SHALL be accepted normally.

Configuration
REQ-027 With macro PIPE_SKID_BUFFER_EN defined, a skid register (valid+data) SHALL sit before stage 0, in_ready SHALL be the registered value !skid_valid (no combinational path from out_ready), the skid captures the input when stage 0 is not ready, drains into stage 0 first, capacity becomes DEPTH+1, and latency rises by 0 when skid empty.
REQ-028 Without PIPE_SKID_BUFFER_EN, no skid register SHALL exist, in_ready follows REQ-015 combinationally, and capacity is DEPTH.

Verification
REQ-029 DEPTH=2, out_ready=1, push 16'h0001..16'h0005 back-to-back -> same sequence on out_data, first valid 2 cycles after first accept, no gaps.
REQ-030 DEPTH=2, out_ready=0, push 3 words -> in_ready falls after 2 accepts (3 with skid), count=2 (3), stall_cnt increments every cycle from first out_valid.
REQ-031 Chain full with 16'hAAAA,16'hBBBB, assert flush with in_valid=1 in_data=16'hCCCC -> next cycle count=0, out_valid=0, 16'hCCCC not accepted.
REQ-032 Full chain, out_ready=1 and in_valid=1 same cycle -> count stays 2, new word accepted, oldest delivered.
REQ-033 Hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF, no wrap.
REQ-034 Pulse reset_n low between clock edges with 2 words held -> out_valid, count, stall_cnt 0 immediately, before next clk edge.
